// File: rtl/problema1_processor_oci_dct_packer.sv
// OCI DCT producer: packs SYM_W-bit trace symbols into SYMS-slot frames and offers them over valid/ready.
// Optional drop counter port dct_drop_cnt is enabled by defining DCT_DROP_COUNT_EN.
module problema1_processor_oci_dct_packer #(
  parameter int SYM_W = 2,
  parameter int SYMS  = 15,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym,
  input  logic                     test_ending,
  output logic [SYM_W*SYMS-1:0]    dct_buffer,
  output logic [CNT_W-1:0]         dct_count,
  output logic                     dct_valid,
  input  logic                     dct_ready,
  output logic                     test_has_ended
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [7:0]               dct_drop_cnt
`endif
);

  localparam int BUF_W = SYM_W * SYMS;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SYMS);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ENDED} state_t;

  state_t             state, state_next;
  logic [BUF_W-1:0]   pack_buf, pack_buf_next, pack_merged;
  logic [CNT_W-1:0]   pack_cnt, pack_cnt_next, cnt_merged;
  logic [BUF_W-1:0]   dct_buffer_next;
  logic [CNT_W-1:0]   dct_count_next;
  logic               dct_valid_next;
  logic               out_free, accept, drop, transfer;

  assign out_free   = !dct_valid || dct_ready;
  assign accept     = (state == RUN) && sym_valid && (pack_cnt != FULL);
  // A held full pack cannot take more symbols, even in the cycle it is handed off.
  assign drop       = (state == RUN) && sym_valid && (pack_cnt == FULL);
  assign cnt_merged = accept ? pack_cnt + 1'b1 : pack_cnt;

  // Pack contents as they would be with this cycle's symbol written in.
  genvar gi;
  generate
    for (gi = 0; gi < SYMS; gi++) begin : g_slot
      assign pack_merged[SYM_W*gi +: SYM_W] =
        (accept && (pack_cnt == CNT_W'(gi))) ? sym : pack_buf[SYM_W*gi +: SYM_W];
    end
  endgenerate

  assign transfer = out_free &&
                    (((state == RUN) && (cnt_merged == FULL)) ||
                     ((state == FLUSH) && (cnt_merged != '0)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (test_ending) state_next = FLUSH;
      FLUSH:   if ((pack_cnt == '0) || out_free) state_next = DRAIN;
      DRAIN:   if (!dct_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = RUN;
    endcase
  end

  // Output decode
  always_comb begin
    test_has_ended = (state == ENDED);
  end

  always_comb begin
    pack_buf_next   = pack_merged;
    pack_cnt_next   = cnt_merged;
    dct_buffer_next = dct_buffer;
    dct_count_next  = dct_count;
    dct_valid_next  = dct_valid;
    if (dct_valid && dct_ready) dct_valid_next = 1'b0;
    if (transfer) begin
      dct_buffer_next = pack_merged;
      dct_count_next  = cnt_merged;
      dct_valid_next  = 1'b1;
      pack_buf_next   = '0;
      pack_cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_buf   <= '0;
      pack_cnt   <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else begin
      pack_buf   <= pack_buf_next;
      pack_cnt   <= pack_cnt_next;
      dct_buffer <= dct_buffer_next;
      dct_count  <= dct_count_next;
      dct_valid  <= dct_valid_next;
    end
  end

`ifdef DCT_DROP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           dct_drop_cnt <= '0;
    else if (drop && dct_drop_cnt != 8'hFF) dct_drop_cnt <= dct_drop_cnt + 8'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_problema1_processor_oci_dct_packer.sv
// Directed bench for the DCT packer: table of single-frame vectors plus hand sequences
// for backpressure, empty flush, async reset and (with DCT_DROP_COUNT_EN) drop saturation.
module tb_problema1_processor_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym = '0;
  logic        test_ending = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b0;
  logic        test_has_ended;
`ifdef DCT_DROP_COUNT_EN
  logic [7:0]  dct_drop_cnt;
`endif

  int tests = 0;
  int failed = 0;

  problema1_processor_oci_dct_packer dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym),
    .test_ending(test_ending), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .test_has_ended(test_has_ended)
`ifdef DCT_DROP_COUNT_EN
    , .dct_drop_cnt(dct_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [29:0] syms;     // symbol k in bits [2k+:2], sent in slot order
    bit          flush;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] s);
    sym_valid = 1'b1;
    sym = s;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sym_valid = 1'b0;
    test_ending = 1'b0;
    dct_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // which: 0 waits for dct_valid, 1 for test_has_ended
  task automatic wait_sig(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step();
      ok = (which == 0) ? dct_valid : test_has_ended;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          seen;
    logic [1:0]  s;
    vec_t        v;

    vecs[0] = '{"full_01",   15, 30'h15555555, 1'b0, 30'h15555555, 4'hF};
    vecs[1] = '{"full_11",   15, 30'h3FFFFFFF, 1'b0, 30'h3FFFFFFF, 4'hF};
    vecs[2] = '{"full_alt",  15, 30'h33333333, 1'b0, 30'h33333333, 4'hF};
    vecs[3] = '{"flush_3",    3, 30'h00000036, 1'b1, 30'h00000036, 4'h3};
    vecs[4] = '{"flush_1",    1, 30'h00000002, 1'b1, 30'h00000002, 4'h1};
    vecs[5] = '{"flush_14",  14, 30'h05555555, 1'b1, 30'h05555555, 4'hE};

    do_reset();
    check("rst_valid", {31'd0, dct_valid}, 32'd0);
    check("rst_count", {28'd0, dct_count}, 32'd0);
    check("rst_buffer", {2'd0, dct_buffer}, 32'd0);
    check("rst_ended", {31'd0, test_has_ended}, 32'd0);
`ifdef DCT_DROP_COUNT_EN
    check("rst_drop", {24'd0, dct_drop_cnt}, 32'd0);
`endif

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      do_reset();
      dct_ready = 1'b1;
      for (int j = 0; j < v.n; j++) begin
        s = v.syms[2*j +: 2];
        send(s);
      end
      if (!v.flush) begin
        check({v.name, "_valid_latency"}, {31'd0, dct_valid}, 32'd1);
        check({v.name, "_buffer"}, {2'd0, dct_buffer}, {2'd0, v.exp_buf});
        check({v.name, "_count"}, {28'd0, dct_count}, {28'd0, v.exp_cnt});
        step();
        check({v.name, "_accepted"}, {31'd0, dct_valid}, 32'd0);
      end else begin
        check({v.name, "_no_early_valid"}, {31'd0, dct_valid}, 32'd0);
        test_ending = 1'b1;
        wait_sig(0, 6, ok);
        check({v.name, "_valid_seen"}, {31'd0, ok}, 32'd1);
        check({v.name, "_buffer"}, {2'd0, dct_buffer}, {2'd0, v.exp_buf});
        check({v.name, "_count"}, {28'd0, dct_count}, {28'd0, v.exp_cnt});
        wait_sig(1, 6, ok);
        check({v.name, "_ended"}, {31'd0, ok}, 32'd1);
        test_ending = 1'b0;
      end
      $display("[TB] vector %s applied", v.name);
    end

    // Backpressure: frame 1 held, frame 2 fills the pack, 31st symbol dropped.
    do_reset();
    for (int j = 0; j < 15; j++) send(2'b11);
    check("bp_f1_valid", {31'd0, dct_valid}, 32'd1);
    check("bp_f1_buffer", {2'd0, dct_buffer}, 32'h3FFFFFFF);
    for (int j = 0; j < 15; j++) send(2'b01);
    send(2'b11);
    check("bp_f1_still_valid", {31'd0, dct_valid}, 32'd1);
    check("bp_f1_stable_buffer", {2'd0, dct_buffer}, 32'h3FFFFFFF);
    check("bp_f1_stable_count", {28'd0, dct_count}, 32'd15);
`ifdef DCT_DROP_COUNT_EN
    check("bp_drop_one", {24'd0, dct_drop_cnt}, 32'd1);
`endif
    dct_ready = 1'b1;
    step();
    check("bp_f2_valid", {31'd0, dct_valid}, 32'd1);
    check("bp_f2_buffer", {2'd0, dct_buffer}, 32'h15555555);
    check("bp_f2_count", {28'd0, dct_count}, 32'd15);
    step();
    check("bp_f2_accepted", {31'd0, dct_valid}, 32'd0);
    send(2'b10);
    test_ending = 1'b1;
    wait_sig(0, 6, ok);
    check("bp_tail_valid", {31'd0, ok}, 32'd1);
    check("bp_tail_buffer", {2'd0, dct_buffer}, 32'h00000002);
    check("bp_tail_count", {28'd0, dct_count}, 32'd1);
    test_ending = 1'b0;
    $display("[TB] sequence backpressure applied");

    // Empty flush: no frame, ended within a few cycles, sticky.
    do_reset();
    dct_ready = 1'b1;
    test_ending = 1'b1;
    seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 && !ok; i++) begin
      step();
      seen |= dct_valid;
      ok = test_has_ended;
    end
    check("empty_ended", {31'd0, ok}, 32'd1);
    check("empty_no_frame", {31'd0, seen}, 32'd0);
    test_ending = 1'b0;
    for (int j = 0; j < 15; j++) send(2'b01);
    step();
    check("empty_ended_sticky", {31'd0, test_has_ended}, 32'd1);
    check("empty_inputs_ignored", {31'd0, dct_valid}, 32'd0);
    $display("[TB] sequence empty_flush applied");

    // Async reset while a frame is offered and a partial pack exists.
    do_reset();
    for (int j = 0; j < 15; j++) send(2'b11);
    for (int j = 0; j < 3; j++) send(2'b10);
    check("ar_valid_before", {31'd0, dct_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", {31'd0, dct_valid}, 32'd0);
    check("ar_count", {28'd0, dct_count}, 32'd0);
    check("ar_buffer", {2'd0, dct_buffer}, 32'd0);
    check("ar_ended", {31'd0, test_has_ended}, 32'd0);
    step();
    reset = 1'b0;
    dct_ready = 1'b1;
    send(2'b01);
    test_ending = 1'b1;
    wait_sig(0, 6, ok);
    check("ar_next_valid", {31'd0, ok}, 32'd1);
    check("ar_next_buffer", {2'd0, dct_buffer}, 32'h00000001);
    check("ar_next_count", {28'd0, dct_count}, 32'd1);
    test_ending = 1'b0;
    $display("[TB] sequence async_reset applied");

`ifdef DCT_DROP_COUNT_EN
    do_reset();
    for (int j = 0; j < 330; j++) send(2'b10);
    check("drop_saturated", {24'd0, dct_drop_cnt}, 32'd255);
    $display("[TB] sequence drop_saturation applied");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
